// File: rtl/sideband_delay_pipe.sv
// -----------------------------------------------------------------------------
// sideband_delay_pipe
//
// Delay line for per-operand sideband data (sign, exponent, flags) in the
// floating-point MAC. Each entry travels through DEPTH register stages next to
// the multiplier/adder datapath, so it reaches the normalise/round stage in the
// same cycle as the matching mantissa result. Every stage has a valid bit. The
// pipe supports stall and flush, and it keeps a count of the valid stages.
//
// Parameters
//   WIDTH     sideband bits per entry ({sign, exponent[7:0]} by default), >= 1
//   DEPTH     number of register stages, equal to the latency in shift cycles, >= 1
//   CW        width of the occupancy count (derived, do not override)
//
// Ports
//   clock     rising-edge clock
//   resetn    asynchronous active-low reset; clears every stage
//   in_valid  an entry is present on in_data this cycle
//   in_data   sideband entry (don't-care when in_valid = 0)
//   stall     hold the whole pipe; the input is not captured
//   flush     invalidate every stage at the next edge (wins over stall)
//   out_valid valid bit of the last stage
//   out_data  data of the last stage; zero when out_valid = 0
//   inflight  number of valid stages
//   idle      high when inflight == 0
// -----------------------------------------------------------------------------
module sideband_delay_pipe #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 10,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    inflight,
  output logic             idle
);

  // Stage 0 is the capture stage and stage DEPTH-1 drives the outputs.
  logic             v_q [DEPTH];
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [CW-1:0]    inflight_q;

  // Action taken at the next edge, resolved in priority order.
  typedef enum logic [1:0] {
    OP_SHIFT,
    OP_HOLD,
    OP_FLUSH
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] in_gated;
  logic [CW-1:0]    inflight_next;

  // NOTE: every signal driven from always_comb gets a default value first.
  //       This prevents a latch if a later branch forgets one of them.
  always_comb begin
    op = OP_SHIFT;
    if (flush) begin
      op = OP_FLUSH;
    end else if (stall) begin
      op = OP_HOLD;
    end
  end

  // An invalid stage always holds zero, so out_data is zero when out_valid is
  // low. The downstream logic needs no extra gating.
  assign in_gated = in_valid ? in_data : '0;

  // On a shift, the entry entering at stage 0 and the entry leaving from the
  // last stage can cancel out. Because the counter tracks the valid bits
  // exactly, it cannot go above DEPTH or below zero.
  assign inflight_next = inflight_q + CW'(in_valid) - CW'(v_q[DEPTH-1]);

  // NOTE: the stage array is cleared by the asynchronous reset. This is
  //       intentional: a reset mid-stream must discard every in-flight entry
  //       and leave each data field at zero.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < DEPTH; k++) begin
        v_q[k] <= 1'b0;
        d_q[k] <= '0;
      end
      inflight_q <= '0;
    end else begin
      unique case (op)
        OP_FLUSH: begin
          for (int k = 0; k < DEPTH; k++) begin
            v_q[k] <= 1'b0;
            d_q[k] <= '0;
          end
          inflight_q <= '0;
        end
        OP_HOLD: begin
          // Every stage and the count keep their values. The entry at the
          // output is presented again next cycle.
        end
        default: begin
          // NOTE: non-blocking assignments let every stage take the old value
          //       of its neighbour, whatever order the loop runs in.
          v_q[0] <= in_valid;
          d_q[0] <= in_gated;
          for (int k = 1; k < DEPTH; k++) begin
            v_q[k] <= v_q[k-1];
            d_q[k] <= d_q[k-1];
          end
          inflight_q <= inflight_next;
        end
      endcase
    end
  end

  // The outputs come straight from the last stage registers. There is no
  // combinational path from the inputs to the outputs.
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign inflight  = inflight_q;
  assign idle      = (inflight_q == '0);

endmodule

// File: tb/tb_sideband_delay_pipe.sv
// -----------------------------------------------------------------------------
// tb_sideband_delay_pipe
//
// Directed bench for sideband_delay_pipe. The default instance (DEPTH=10,
// WIDTH=9) runs the reset/latency, streaming, stall, flush and async-reset
// scenarios. Two more instances (DEPTH=1/WIDTH=1 and DEPTH=16/WIDTH=32) take
// random in_valid/stall/flush traffic, and their outputs are compared with a
// queue-based scoreboard. In that scoreboard each accepted entry counts down
// the shifts it still needs before it reaches the output.
// -----------------------------------------------------------------------------
module tb_sideband_delay_pipe;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  // Default instance: DEPTH=10, WIDTH=9.
  logic       in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [8:0] in_data = '0;
  logic       out_valid, idle;
  logic [8:0] out_data;
  logic [3:0] inflight;

  sideband_delay_pipe u_dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
    .stall(stall), .flush(flush), .out_valid(out_valid), .out_data(out_data),
    .inflight(inflight), .idle(idle)
  );

  // Sweep instance A: DEPTH=1, WIDTH=1.
  logic       a_in_valid = 1'b0, a_stall = 1'b0, a_flush = 1'b0;
  logic [0:0] a_in_data = '0;
  logic       a_out_valid, a_idle;
  logic [0:0] a_out_data;
  logic [0:0] a_inflight;

  sideband_delay_pipe #(.WIDTH(1), .DEPTH(1)) u_dut_a (
    .clock(clock), .resetn(resetn), .in_valid(a_in_valid), .in_data(a_in_data),
    .stall(a_stall), .flush(a_flush), .out_valid(a_out_valid), .out_data(a_out_data),
    .inflight(a_inflight), .idle(a_idle)
  );

  // Sweep instance B: DEPTH=16, WIDTH=32.
  logic        b_in_valid = 1'b0, b_stall = 1'b0, b_flush = 1'b0;
  logic [31:0] b_in_data = '0;
  logic        b_out_valid, b_idle;
  logic [31:0] b_out_data;
  logic [4:0]  b_inflight;

  sideband_delay_pipe #(.WIDTH(32), .DEPTH(16)) u_dut_b (
    .clock(clock), .resetn(resetn), .in_valid(b_in_valid), .in_data(b_in_data),
    .stall(b_stall), .flush(b_flush), .out_valid(b_out_valid), .out_data(b_out_data),
    .inflight(b_inflight), .idle(b_idle)
  );

  int n_compared = 0;
  int n_mismatched = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clock edge, then a short settle so that outputs are sampled away
  // from the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard entry: data and the number of shifts it still needs before it
  // reaches the output.
  typedef struct {
    logic [31:0] data;
    int          rem;
  } sb_t;

  sb_t q_a[$];
  sb_t q_b[$];

  int          exp_inf;
  logic        exp_ov;
  logic [31:0] exp_od;

  initial begin
    // ---------------- Reset state ----------------
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_inflight",  32'(inflight),  32'd0);
    check("rst_idle",      32'(idle),      32'd1);
    resetn = 1'b1;       // released between edges
    tick();

    // ---------------- Reset/latency: single entry 9'h1A5 ----------------
    in_valid = 1'b1; in_data = 9'h1A5;
    tick();              // capture edge (edge 1)
    in_valid = 1'b0; in_data = 9'h0FF;   // don't-care data while invalid
    for (int t = 1; t <= 12; t++) begin
      if (t > 1) tick();
      check("lat_out_valid", 32'(out_valid), (t == 10) ? 32'd1 : 32'd0);
      check("lat_out_data",  32'(out_data),  (t == 10) ? 32'h1A5 : 32'd0);
      check("lat_inflight",  32'(inflight),  (t <= 10) ? 32'd1 : 32'd0);
    end
    check("lat_idle_after", 32'(idle), 32'd1);

    // ---------------- Streaming 0..19 ----------------
    // Entry e is captured at edge e+1, appears after edge e+10 and leaves at
    // edge e+11.
    for (int t = 1; t <= 31; t++) begin
      if (t <= 20) begin
        in_valid = 1'b1; in_data = 9'(t - 1);
      end else begin
        in_valid = 1'b0; in_data = '0;
      end
      tick();
      exp_inf = ((t < 20) ? t : 20) - ((t - 10 < 0) ? 0 : ((t - 10 > 20) ? 20 : t - 10));
      check("strm_out_valid", 32'(out_valid), (t >= 10 && t <= 29) ? 32'd1 : 32'd0);
      check("strm_out_data",  32'(out_data),  (t >= 10 && t <= 29) ? 32'(t - 10) : 32'd0);
      check("strm_inflight",  32'(inflight),  32'(exp_inf));
    end
    in_valid = 1'b0;
    for (int t = 0; t < 3; t++) tick();

    // ---------------- Stall ----------------
    // Entries 0..5 at edges 1..6. Entry 2 appears after edge 12, with
    // entries 2..5 in flight. Edges 13..15 are stalled. Entry 3 appears
    // after edge 16.
    for (int t = 1; t <= 20; t++) begin
      in_valid = (t <= 6);
      in_data  = (t <= 6) ? 9'(t - 1) : 9'h0;
      stall    = (t >= 13 && t <= 15);
      tick();
      if (t >= 12 && t <= 15) begin
        check("stl_hold_valid", 32'(out_valid), 32'd1);
        check("stl_hold_data",  32'(out_data),  32'd2);
        check("stl_hold_infl",  32'(inflight),  32'd4);
      end
      if (t == 16) begin
        check("stl_next_data", 32'(out_data), 32'd3);
        check("stl_next_infl", 32'(inflight), 32'd3);
      end
      if (t == 18) check("stl_last_data", 32'(out_data), 32'd5);
      if (t == 20) check("stl_drained", 32'(idle), 32'd1);
    end
    stall = 1'b0; in_valid = 1'b0;

    // ---------------- Flush (with in_valid and stall also high) ----------------
    for (int t = 0; t < 6; t++) begin
      in_valid = 1'b1; in_data = 9'h40 + 9'(t);
      tick();
    end
    check("fl_pre_infl", 32'(inflight), 32'd6);
    in_valid = 1'b1; in_data = 9'h1FF; stall = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; in_data = '0; stall = 1'b0; flush = 1'b0;
    check("fl_inflight",  32'(inflight),  32'd0);
    check("fl_idle",      32'(idle),      32'd1);
    check("fl_out_valid", 32'(out_valid), 32'd0);
    for (int t = 0; t < 10; t++) begin
      tick();
      check("fl_no_emerge", 32'({out_valid, out_data}), 32'd0);
    end

    // ---------------- Async reset mid-stream ----------------
    for (int t = 0; t < 7; t++) begin
      in_valid = 1'b1; in_data = 9'h150 + 9'(t);
      tick();
    end
    in_valid = 1'b0;
    for (int t = 0; t < 3; t++) tick();
    check("ar_pre_valid", 32'(out_valid), 32'd1);
    check("ar_pre_data",  32'(out_data),  32'h150);
    check("ar_pre_infl",  32'(inflight),  32'd7);
    #2 resetn = 1'b0;    // between edges
    #1;
    check("ar_out_valid", 32'(out_valid), 32'd0);
    check("ar_out_data",  32'(out_data),  32'd0);
    check("ar_inflight",  32'(inflight),  32'd0);
    check("ar_idle",      32'(idle),      32'd1);
    #3 resetn = 1'b1;
    for (int t = 0; t < 15; t++) begin
      tick();
      check("ar_no_emerge", 32'({out_valid, out_data}), 32'd0);
    end

    // ---------------- Parameter sweep with scoreboard ----------------
    for (int c = 0; c < 400; c++) begin
      a_in_valid = 1'($urandom_range(0, 1));
      a_in_data  = 1'($urandom_range(0, 1));
      a_stall    = ($urandom_range(0, 3) == 0);
      a_flush    = ($urandom_range(0, 19) == 0);
      b_in_valid = ($urandom_range(0, 3) != 0);
      b_in_data  = $urandom;
      b_stall    = ($urandom_range(0, 4) == 0);
      b_flush    = ($urandom_range(0, 39) == 0);
      tick();

      // Model for instance A (DEPTH=1).
      if (a_flush) begin
        q_a.delete();
      end else if (!a_stall) begin
        if (q_a.size() > 0 && q_a[0].rem == 0) void'(q_a.pop_front());
        foreach (q_a[i]) q_a[i].rem--;
        if (a_in_valid) q_a.push_back('{data: 32'(a_in_data), rem: 0});
      end
      exp_ov  = (q_a.size() > 0 && q_a[0].rem == 0);
      exp_od  = exp_ov ? q_a[0].data : 32'd0;
      exp_inf = q_a.size();
      check("swA_out_valid", 32'(a_out_valid), 32'(exp_ov));
      check("swA_out_data",  32'(a_out_data),  exp_od);
      check("swA_inflight",  32'(a_inflight),  32'(exp_inf));
      check("swA_idle",      32'(a_idle),      32'(exp_inf == 0));

      // Model for instance B (DEPTH=16).
      if (b_flush) begin
        q_b.delete();
      end else if (!b_stall) begin
        if (q_b.size() > 0 && q_b[0].rem == 0) void'(q_b.pop_front());
        foreach (q_b[i]) q_b[i].rem--;
        if (b_in_valid) q_b.push_back('{data: b_in_data, rem: 15});
      end
      exp_ov  = (q_b.size() > 0 && q_b[0].rem == 0);
      exp_od  = exp_ov ? q_b[0].data : 32'd0;
      exp_inf = q_b.size();
      check("swB_out_valid", 32'(b_out_valid), 32'(exp_ov));
      check("swB_out_data",  b_out_data,       exp_od);
      check("swB_inflight",  32'(b_inflight),  32'(exp_inf));
      check("swB_idle",      32'(b_idle),      32'(exp_inf == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/sideband_delay_pipe.md
# sideband_delay_pipe

Parametrised delay line that carries per-operand sideband data (exponent, sign, flags) alongside the multiplier/adder datapath of the floating-point MAC so that it arrives aligned with the mantissa result. It is the successor to the fixed 10-stage exponent/sign buffer and adds:
- configurable width and depth,
- a per-stage valid bit,
- pipeline stall and flush,
- an in-flight occupancy counter.

Sits between the operand-unpack stage and the normalise/round stage.

## Interface
- `WIDTH`, default 9: sideband bits per entry, packed `{sign, exponent[7:0]}` by convention; must be ≥ 1.
- `DEPTH`, default 10: number of register stages, equal to the latency in non-stalled cycles; must be ≥ 1.
- `CW`, default `$clog2(DEPTH+1)`: width of the occupancy count; derived, never overridden.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset; clears all state immediately.
- `in_valid`  in  1  entry present on `in_data` this cycle.
- `in_data`  in  `WIDTH`  sideband entry.
- `stall`  in  1  hold the whole pipe; input ignored.
- `flush`  in  1  invalidate every stage at the next edge.
- `out_valid`  out  1  valid bit of the last stage.
- `out_data`  out  `WIDTH`  data of the last stage; zero when `out_valid`=0.
- `inflight`  out  `CW`  number of valid stages.
- `idle`  out  1  high when `inflight`==0.

## Operation
- State: stages 1..`DEPTH`, each holding `v[k]` and `d[k][WIDTH-1:0]`. Stage `DEPTH` drives `out_valid`/`out_data` directly from registers, with no combinational path from the inputs.
- Priority at each edge: `flush` > `stall` > shift.
- **Flush** (`flush`=1):
  - all `v[k]`←0, all `d[k]`←0, `inflight`←0;
  - `in_valid`/`in_data` are discarded that cycle;
  - `stall` is ignored.
- **Stall** (`flush`=0, `stall`=1):
  - every `v`, `d` and `inflight` holds;
  - the input is not captured, so upstream must stall in the same cycle;
  - `out_valid`/`out_data` hold, and the same entry is presented again next cycle.
- **Shift** (`flush`=0, `stall`=0):
  - `v[1]`←`in_valid`, and `d[1]`←(`in_valid` ? `in_data` : 0);
  - `v[k]`←`v[k-1]` and `d[k]`←`d[k-1]` for k = 2..`DEPTH`;
  - the entry in stage `DEPTH` leaves the pipe; it was consumed on the previous `out_valid`.
- **Data gating:** an invalid stage always holds `d`=0, so `out_data` is 0 whenever `out_valid`=0. `in_data` is don't-care when `in_valid`=0.
- **Occupancy counter:**
  - on shift: `inflight`←`inflight` + `in_valid` − `v[DEPTH]`;
  - on stall: holds; on flush: ←0.
  - Never exceeds `DEPTH` and never underflows. The bench asserts that `inflight` always equals the popcount of `v`.
- `idle` is combinational from `inflight`==0.
- `DEPTH`=1 is a single register stage with the same rules.

## Timing
- Reset (`resetn`=0, asynchronous): all `v`=0, all `d`=0, `out_valid`=0, `out_data`=0, `inflight`=0, `idle`=1. State is released on the first rising edge after `resetn` deasserts.
- Latency: an entry accepted at edge N (shift cycle) appears at `out_valid` after exactly `DEPTH` shift edges. Each stalled cycle adds one cycle.
- Throughput: one entry per non-stalled cycle; back-to-back valid entries are preserved with no bubbles inserted.
- Simultaneous `flush` and `stall`: flush wins. The entry on the input that cycle is lost.
- Reset mid-operation: all in-flight entries are discarded immediately, with no partial outputs.
- Simultaneous input and output on a shift (`in_valid`=1, `v[DEPTH]`=1): `inflight` is unchanged.

## Test plan
- **Reset/latency:** `DEPTH`=10, `WIDTH`=9.
  - Deassert reset, send one entry `9'h1A5` at cycle 0.
  - Expect `out_valid`=1 with `out_data`=`9'h1A5` at cycle 10 only, and `out_data`=0 on every other cycle.
  - `inflight` reads 1 from cycle 1 through cycle 10, then 0.
- **Streaming:** 20 consecutive entries 0..19.
  - Outputs are 0..19 on cycles 10..29 with no gaps.
  - `inflight` saturates at 10.
- **Stall:** stream 0..5, then assert `stall` for 3 cycles starting at cycle 12.
  - `out_data`=2 is held for cycles 12–15.
  - Entry 3 appears at cycle 16.
  - `inflight` is constant during the stall.
- **Flush:** fill with 6 entries, then assert `flush` together with `in_valid`=1 and `stall`=1.
  - Next cycle: `inflight`=0, `idle`=1, `out_valid`=0.
  - No entry emerges in the following 10 cycles.
- **Async reset mid-stream:** pull `resetn` low between clock edges while 7 entries are in flight.
  - Outputs go to 0 immediately.
  - After release, nothing emerges from the old stream.
- **Parameter sweep:** run `DEPTH`=1, `WIDTH`=1 and `DEPTH`=16, `WIDTH`=32 with random `in_valid`/`stall`/`flush`.
  - Output order and latency match a scoreboard model.
  - `inflight` equals the popcount of `v` every cycle.
